// File: rtl/cl_pcim_wr_pkg.sv
// Shared types and constants for the PCIM stream writer.
package cl_pcim_wr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    AW,
    W,
    B
  } wr_state_e;

  localparam logic [2:0] AXSIZE_64B     = 3'b110;
  localparam int         BYTES_PER_BEAT = 64;
  localparam int         PAGE_BYTES     = 4096;

endpackage

// File: rtl/cl_pcim_stream_writer.sv
// AXI4 write master draining a 512-bit stream into host memory as fixed-size,
// page-aligned bursts with one burst outstanding at a time.
//
// state | meaning
// IDLE  | waiting for cfg_start; no valids, s_ready low
// AW    | presenting the burst address
// W     | passing stream beats straight through to the W channel
// B     | waiting for the write response of the current burst
module cl_pcim_stream_writer
  import cl_pcim_wr_pkg::*;
#(
  parameter int          BURST_LEN = 64,
  parameter logic [15:0] AWID_VAL  = 16'h0
) (
  input  logic         clk,
  input  logic         rst_n,

  input  logic         cfg_start,
  input  logic [63:0]  cfg_base,
  input  logic [15:0]  cfg_num_bursts,

  input  logic         s_valid,
  output logic         s_ready,
  input  logic [511:0] s_data,

  output logic [15:0]  cl_sh_pcim_awid,
  output logic [63:0]  cl_sh_pcim_awaddr,
  output logic [7:0]   cl_sh_pcim_awlen,
  output logic [2:0]   cl_sh_pcim_awsize,
  output logic         cl_sh_pcim_awvalid,
  input  logic         sh_cl_pcim_awready,

  output logic [511:0] cl_sh_pcim_wdata,
  output logic [63:0]  cl_sh_pcim_wstrb,
  output logic         cl_sh_pcim_wlast,
  output logic         cl_sh_pcim_wvalid,
  input  logic         sh_cl_pcim_wready,

  input  logic [15:0]  sh_cl_pcim_bid,
  input  logic [1:0]   sh_cl_pcim_bresp,
  input  logic         sh_cl_pcim_bvalid,
  output logic         cl_sh_pcim_bready,

  output logic         stat_busy,
  output logic         stat_done,
  output logic         stat_err,
  output logic [15:0]  stat_bursts
);

  localparam int                BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [63:0]       BURST_BYTES = 64'(BURST_LEN * BYTES_PER_BEAT);

  wr_state_e         state, state_nxt;
  logic [63:0]       cur_addr;
  logic [15:0]       remaining;
  logic [BEAT_W-1:0] beat;
  logic              done_q;
  logic              err_q;
  logic [15:0]       bursts_q;

  logic start_ok, aw_hs, w_hs, b_hs, last_b;
  logic unused;

  assign start_ok = (state == IDLE) && cfg_start;
  assign aw_hs    = (state == AW) && sh_cl_pcim_awready;
  assign w_hs     = (state == W) && s_valid && sh_cl_pcim_wready;
  assign b_hs     = (state == B) && sh_cl_pcim_bvalid;
  assign last_b   = b_hs && (remaining == 16'd1);

  // Low address bits and the response ID are intentionally ignored.
  assign unused = ^{cfg_base[11:0], sh_cl_pcim_bid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cfg_start && (cfg_num_bursts != 16'd0)) state_nxt = AW;
      AW:   if (sh_cl_pcim_awready) state_nxt = W;
      W:    if (w_hs && (beat == LAST_BEAT)) state_nxt = B;
      B:    if (sh_cl_pcim_bvalid) state_nxt = last_b ? IDLE : AW;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cl_sh_pcim_awvalid = 1'b0;
    cl_sh_pcim_wvalid  = 1'b0;
    cl_sh_pcim_wlast   = 1'b0;
    cl_sh_pcim_bready  = 1'b0;
    s_ready            = 1'b0;
    case (state)
      AW: cl_sh_pcim_awvalid = 1'b1;
      W: begin
        cl_sh_pcim_wvalid = s_valid;
        s_ready           = sh_cl_pcim_wready;
        cl_sh_pcim_wlast  = (beat == LAST_BEAT);
      end
      B: cl_sh_pcim_bready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= 64'd0;
      remaining <= 16'd0;
      beat      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bursts_q  <= 16'd0;
    end else begin
      done_q <= (start_ok && (cfg_num_bursts == 16'd0)) || last_b;
      if (start_ok) begin
        cur_addr  <= {cfg_base[63:12], 12'h000};
        remaining <= cfg_num_bursts;
        err_q     <= 1'b0;
        bursts_q  <= 16'd0;
      end
      if (aw_hs) beat <= '0;
      if (w_hs)  beat <= beat + 1'b1;
      if (b_hs) begin
        err_q     <= err_q | (sh_cl_pcim_bresp != 2'b00);
        bursts_q  <= bursts_q + 16'd1;
        cur_addr  <= cur_addr + BURST_BYTES;
        remaining <= remaining - 16'd1;
      end
    end
  end

  // AW fields come from registers, so they hold steady while awready is low.
  assign cl_sh_pcim_awid   = AWID_VAL;
  assign cl_sh_pcim_awaddr = cur_addr;
  assign cl_sh_pcim_awlen  = 8'(BURST_LEN - 1);
  assign cl_sh_pcim_awsize = AXSIZE_64B;

  assign cl_sh_pcim_wdata = s_data;
  assign cl_sh_pcim_wstrb = {64{1'b1}};

  assign stat_busy   = (state != IDLE);
  assign stat_done   = done_q;
  assign stat_err    = err_q;
  assign stat_bursts = bursts_q;

endmodule

// File: tb/tb_cl_pcim_stream_writer.sv
// Directed bench: drives jobs through a simple shell model and checks AW/W/B
// traffic, data ordering and status against bench-computed expectations.
module tb_cl_pcim_stream_writer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_start;
  logic [63:0]  cfg_base;
  logic [15:0]  cfg_num_bursts;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] s_data;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [15:0]  bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic         stat_busy;
  logic         stat_done;
  logic         stat_err;
  logic [15:0]  stat_bursts;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cl_pcim_stream_writer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cfg_start          (cfg_start),
    .cfg_base           (cfg_base),
    .cfg_num_bursts     (cfg_num_bursts),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_data             (s_data),
    .cl_sh_pcim_awid    (awid),
    .cl_sh_pcim_awaddr  (awaddr),
    .cl_sh_pcim_awlen   (awlen),
    .cl_sh_pcim_awsize  (awsize),
    .cl_sh_pcim_awvalid (awvalid),
    .sh_cl_pcim_awready (awready),
    .cl_sh_pcim_wdata   (wdata),
    .cl_sh_pcim_wstrb   (wstrb),
    .cl_sh_pcim_wlast   (wlast),
    .cl_sh_pcim_wvalid  (wvalid),
    .sh_cl_pcim_wready  (wready),
    .sh_cl_pcim_bid     (bid),
    .sh_cl_pcim_bresp   (bresp),
    .sh_cl_pcim_bvalid  (bvalid),
    .cl_sh_pcim_bready  (bready),
    .stat_busy          (stat_busy),
    .stat_done          (stat_done),
    .stat_err           (stat_err),
    .stat_bursts        (stat_bursts)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk(input int i);
    logic [31:0] w;
    w = 32'(i) ^ 32'hA5A5_0000;
    return {16{w}};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
    chk({tag, "_wvalid"},  wvalid,  1'b0);
    chk({tag, "_wlast"},   wlast,   1'b0);
    chk({tag, "_bready"},  bready,  1'b0);
    chk({tag, "_s_ready"}, s_ready, 1'b0);
    chk({tag, "_busy"},    stat_busy, 1'b0);
    chk({tag, "_done"},    stat_done, 1'b0);
    chk({tag, "_err"},     stat_err,  1'b0);
    chk({tag, "_bursts"},  stat_bursts, 16'd0);
  endtask

  // One job against a shell model. bp: random backpressure; bad_burst: index
  // answered with SLVERR; start_beat: stray cfg_start in W; rst_beat: abort.
  task automatic run_job(input logic [63:0] base, input logic [15:0] n, input bit bp,
                         input int bad_burst, input int start_beat, input int rst_beat);
    int aw_n = 0, b_n = 0, beats = 0, beat_in = 0, guard = 0;
    bit done_seen = 0, b_pending = 0, inj = 0, exp_err;
    logic [63:0] ea;
    exp_err = (bad_burst >= 0) && (bad_burst < int'(n));

    @(negedge clk);
    cfg_base = base; cfg_num_bursts = n; cfg_start = 1'b1;
    s_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;

    while (!done_seen && guard < 5000) begin
      s_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = mk(beat_in);
      awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = bp ? guard[0] : 1'b1;
      bvalid  = b_pending && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      bresp   = (b_n == bad_burst) ? 2'b10 : 2'b00;
      bid     = 16'h00A5;
      cfg_start = (start_beat >= 0) && (beats == start_beat) && !inj;
      if (cfg_start) begin
        cfg_base = 64'hDEAD_BEEF_0000_0000; cfg_num_bursts = 16'd9; inj = 1;
      end
      if (rst_beat >= 0 && beats == rst_beat) begin
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      #1;
      if (guard == 0) begin
        chk("first_awvalid", awvalid,   n != 16'd0);
        chk("first_busy",    stat_busy, n != 16'd0);
        chk("zero_done",     stat_done, n == 16'd0);
      end
      if (stat_done) begin
        done_seen = 1;
        chk("done_after_last_b", b_n, n);
      end
      if (awvalid && awready) begin
        ea = {base[63:12], 12'h000} + 64'(aw_n) * 64'd4096;
        chk("awaddr", awaddr, ea);
        chk("awlen",  awlen,  8'd63);
        chk("awsize", awsize, 3'b110);
        chk("awid",   awid,   16'h0);
        chk("one_outstanding", aw_n, b_n);
        aw_n++;
      end
      if (wvalid && wready) begin
        chk("w_after_aw", aw_n, b_n + 1);
        chk("wdata", wdata, mk(beats));
        chk("wstrb", wstrb, {64{1'b1}});
        chk("wlast", wlast, (beats % 64) == 63);
        if (wlast) b_pending = 1;
        beats++;
      end
      if (s_valid && s_ready) beat_in++;
      if (bvalid && bready) begin
        b_n++;
        b_pending = 0;
      end
      @(negedge clk);
      guard++;
    end

    if (!done_seen) chk("done_timeout", 1'b0, 1'b1);
    chk("aw_count",    aw_n, n);
    chk("b_count",     b_n,  n);
    chk("beat_count",  beats, int'(n) * 64);
    chk("beats_in_eq_out", beat_in, beats);
    chk("stat_bursts", stat_bursts, n);
    chk("stat_err",    stat_err, exp_err);
    chk("busy_at_done", stat_busy, 1'b0);
    #1;
    chk("done_width", stat_done, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_base = '0; cfg_num_bursts = '0;
    s_valid = 1'b1; s_data = '0; awready = 1'b1; wready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; bid = 16'h0;
    #1;
    chk_quiet("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b0;

    run_job(64'h0000_0001_0000_1234, 16'd2, 1'b0, -1, -1, -1);
    run_job(64'h0000_00AB_CDEF_5FFF, 16'd3, 1'b1, -1, -1, -1);
    run_job(64'h0000_0000_0000_2000, 16'd3, 1'b0,  1, -1, -1);
    run_job(64'h0000_0000_0000_3000, 16'd0, 1'b0, -1, -1, -1);
    run_job(64'h0000_0000_0000_4000, 16'd2, 1'b0, -1,  5, -1);
    run_job(64'h0000_0000_0000_5000, 16'd2, 1'b0, -1, -1, 10);
    run_job(64'hFFFF_FFFF_FFFF_F123, 16'd2, 1'b0, -1, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
